// File: rtl/rng_arbiter.sv
// rng_arbiter: round-robin sharing of one xorshift PRNG
// with run-time reseed and discarded warmup steps after each seed load.
module rng_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int RANDOM_WIDTH  = 32,
  parameter logic [RANDOM_WIDTH-1:0] SEED = 1,
  parameter int WARMUP_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req,
  output logic [NUM_REQ-1:0]      gnt,
  output logic                    rnd_valid,
  output logic [RANDOM_WIDTH-1:0] rnd_data,
  input  logic                    reseed_valid,
  input  logic [RANDOM_WIDTH-1:0] reseed_data,
  output logic                    reseed_ready,
  output logic                    busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(WARMUP_CYCLES + 2);

  typedef logic [RANDOM_WIDTH-1:0] word_t;
  typedef enum logic {WARMUP, READY} state_t;

  state_t        fsm;
  word_t         s;
  logic [CW-1:0] warm_cnt;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] win_nxt;
  logic [PW:0]   scan;
  logic          any_req;

  function automatic word_t xs_step(input word_t v);
    return v ^ (v << 13) ^ (v >> 17) ^ (v << 5);
  endfunction

  // A zero seed would lock the engine at zero forever.
  function automatic word_t fix_seed(input word_t v);
    return (v == '0) ? word_t'(1) : v;
  endfunction

  // Walk from the far end so the last hit is the
  // nearest set bit at or after rr_ptr.
  always_comb begin
    win  = rr_ptr;
    scan = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      scan = {1'b0, rr_ptr} + (PW+1)'(i);
      if (scan >= (PW+1)'(NUM_REQ))
        scan = scan - (PW+1)'(NUM_REQ);
      if (req[scan[PW-1:0]])
        win = scan[PW-1:0];
    end
  end

  assign any_req = |req;
  assign win_nxt = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;

  assign reseed_ready = (fsm == READY);
  assign busy         = (fsm == WARMUP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s         <= fix_seed(SEED);
      fsm       <= WARMUP;
      warm_cnt  <= '0;
      rr_ptr    <= '0;
      gnt       <= '0;
      rnd_valid <= 1'b0;
      rnd_data  <= '0;
    end else begin
      gnt       <= '0;
      rnd_valid <= 1'b0;
      unique case (fsm)
        WARMUP: begin
          if (warm_cnt == CW'(WARMUP_CYCLES)) begin
            fsm <= READY;
          end else begin
            s        <= xs_step(s);
            warm_cnt <= warm_cnt + 1'b1;
          end
        end
        READY: begin
          if (reseed_valid) begin
            s        <= fix_seed(reseed_data);
            warm_cnt <= '0;
            fsm      <= WARMUP;
          end else if (any_req) begin
            gnt       <= NUM_REQ'(1) << win;
            rnd_valid <= 1'b1;
            rnd_data  <= s;
            s         <= xs_step(s);
            rr_ptr    <= win_nxt;
          end
        end
        default: fsm <= WARMUP;
      endcase
    end
  end

endmodule

// File: tb/tb_rng_arbiter.sv
// tb_rng_arbiter: directed scoreboard bench for rng_arbiter
// (warmup-free instance plus a default-warmup instance).
module tb_rng_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic        rnd_valid;
  logic [31:0] rnd_data;
  logic        reseed_valid;
  logic [31:0] reseed_data;
  logic        reseed_ready;
  logic        busy;

  logic [3:0]  req4;
  logic [3:0]  gnt4;
  logic        rnd_valid4;
  logic [31:0] rnd_data4;
  logic        rs_valid4;
  logic [31:0] rs_data4;
  logic        reseed_ready4;
  logic        busy4;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [3:0]  gnt;
    logic        v;
    logic [31:0] data;
    logic        busy;
  } exp_t;

  exp_t q[$];

  logic [31:0] m_s;
  logic [31:0] m_data;
  int          m_ptr;
  int          m_cnt;
  bit          m_warm;

  always #5 clk = ~clk;

  rng_arbiter #(.WARMUP_CYCLES(0)) u0 (
    .clk(clk), .reset_n(reset_n), .req(req), .gnt(gnt),
    .rnd_valid(rnd_valid), .rnd_data(rnd_data),
    .reseed_valid(reseed_valid), .reseed_data(reseed_data),
    .reseed_ready(reseed_ready), .busy(busy)
  );

  rng_arbiter u4 (
    .clk(clk), .reset_n(reset_n), .req(req4), .gnt(gnt4),
    .rnd_valid(rnd_valid4), .rnd_data(rnd_data4),
    .reseed_valid(rs_valid4), .reseed_data(rs_data4),
    .reseed_ready(reseed_ready4), .busy(busy4)
  );

  function automatic logic [31:0] xs(input logic [31:0] v);
    return v ^ (v << 13) ^ (v >> 17) ^ (v << 5);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s    = 32'd1;
    m_data = 32'd0;
    m_ptr  = 0;
    m_cnt  = 0;
    m_warm = 1'b1;
  endtask

  // Drive one cycle on u0; the model predicts the post-edge outputs.
  task automatic step(input logic [3:0] r, input logic rv = 1'b0,
                      input logic [31:0] rd = 32'd0);
    exp_t e;
    int   w;
    int   idx;
    req = r;
    reseed_valid = rv;
    reseed_data = rd;
    e.gnt = 4'd0;
    e.v = 1'b0;
    if (m_warm) begin
      if (m_cnt == 0) begin
        m_warm = 1'b0;
      end else begin
        m_s = xs(m_s);
        m_cnt++;
      end
    end else if (rv) begin
      m_s = (rd == 32'd0) ? 32'd1 : rd;
      m_cnt = 0;
      m_warm = 1'b1;
    end else if (r != 4'd0) begin
      w = -1;
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (w < 0 && r[2'(idx)]) w = idx;
      end
      e.gnt = 4'(1 << w);
      e.v = 1'b1;
      m_data = m_s;
      m_s = xs(m_s);
      m_ptr = (w + 1) % 4;
    end
    e.data = m_data;
    e.busy = m_warm;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("gnt", 32'(gnt), 32'(e.gnt));
    chk("rnd_valid", 32'(rnd_valid), 32'(e.v));
    chk("rnd_data", rnd_data, e.data);
    chk("busy", 32'(busy), 32'(e.busy));
    chk("reseed_ready", 32'(reseed_ready), 32'(!e.busy));
  endtask

  initial begin
    reset_n = 1'b0;
    req = 4'd0;
    reseed_valid = 1'b0;
    reseed_data = 32'd0;
    req4 = 4'd0;
    rs_valid4 = 1'b0;
    rs_data4 = 32'd0;
    model_reset();
    #12;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_valid", 32'(rnd_valid), 32'd0);
    chk("rst_data", rnd_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_ready", 32'(reseed_ready), 32'd0);
    chk("rst_busy4", 32'(busy4), 32'd1);

    // Default warmup of 4: five quiet edges, then 4th successor of 1.
    req4 = 4'b0001;
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(4'd0);
      chk("t5_gnt4", 32'(gnt4), 32'd0);
      chk("t5_busy4", 32'(busy4), 32'(i < 4));
      chk("t5_ready4", 32'(reseed_ready4), 32'(i == 4));
    end
    step(4'd0);
    chk("t5_gnt4_first", 32'(gnt4), 32'd1);
    chk("t5_valid4", 32'(rnd_valid4), 32'd1);
    chk("t5_data4", rnd_data4, xs(xs(xs(xs(32'd1)))));
    req4 = 4'd0;

    // Fresh reset with req=0001 held.
    reset_n = 1'b0;
    req = 4'b0001;
    model_reset();
    @(negedge clk) reset_n = 1'b1;
    step(4'b0001);
    chk("t1_nogrant", 32'(gnt), 32'd0);
    step(4'b0001);
    chk("t1_w0", rnd_data, 32'h0000_0001);
    step(4'b0001);
    chk("t1_w1", rnd_data, 32'h0000_2021);
    step(4'b0001);
    chk("t1_w2", rnd_data, 32'h0400_0401);

    for (int i = 0; i < 5; i++) step(4'b1111);

    step(4'b0100);
    chk("t3_g0100", 32'(gnt), 32'b0100);
    step(4'b0101);
    chk("t3_g0001", 32'(gnt), 32'b0001);
    step(4'b0101);
    chk("t3_g0100b", 32'(gnt), 32'b0100);

    step(4'b0001, 1'b1, 32'd0);
    chk("t4_nogrant", 32'(gnt), 32'd0);
    chk("t4_busy", 32'(busy), 32'd1);
    step(4'b0001);
    step(4'b0001);
    chk("t4_seed1", rnd_data, 32'd1);

    step(4'd0);
    step(4'd0);

    for (int i = 0; i < 30; i++)
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0),
           (($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom)));

    step(4'd0);
    step(4'd0);
    step(4'b0010);
    chk("t6_g0010", 32'(gnt), 32'b0010);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_gnt", 32'(gnt), 32'd0);
    chk("t6_valid", 32'(rnd_valid), 32'd0);
    chk("t6_data", rnd_data, 32'd0);
    req = 4'b0001;
    model_reset();
    @(negedge clk) reset_n = 1'b1;
    step(4'b0001);
    step(4'b0001);
    chk("t6_w0", rnd_data, 32'h0000_0001);
    step(4'b0001);
    chk("t6_w1", rnd_data, 32'h0000_2021);
    step(4'b0001);
    chk("t6_w2", rnd_data, 32'h0400_0401);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
